// File: rtl/uart_pkg.sv
// uart_pkg: shared UART receiver constants and FSM state encoding.
// Contents: state_t (IDLE, START, DATA, PARITY, STOP, BREAK), OS_RATE,
// MID_SAMPLE, LAST_SAMPLE and DEF_OS_DIV (12 MHz / (9600*16), truncated).
package uart_pkg;
   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
   } state_t;
   localparam int         OS_RATE     = 16;
   localparam logic [3:0] MID_SAMPLE  = 4'd7;
   localparam logic [3:0] LAST_SAMPLE = 4'd15;
   localparam int         DEF_OS_DIV  = 78;
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running 0..OS_DIV-1 counter; o_tick is high for one clk when it wraps.
// Ports: clk, rst (sync, active-high), o_tick (oversample strobe).
module uart_baud_tick #(
   parameter int OS_DIV = 78
) (
   input  logic clk,
   input  logic rst,
   output logic o_tick
);
   localparam int W = $clog2(OS_DIV);
   logic [W-1:0] r_cnt;
   assign o_tick = (r_cnt == W'(OS_DIV - 1));
   always_ff @(posedge clk)
      r_cnt <= (rst || o_tick) ? '0 : r_cnt + W'(1);
endmodule

// File: rtl/uart_rx_8n1.sv
// uart_rx_8n1: 16x-oversampled 8N1 UART receiver with valid/ready holding register.
// Ports: clk, rst (sync, active-high), i_rx (async line, idle high),
//   o_rx_data/o_rx_valid/i_rx_ready (byte handshake), o_rx_frame_err (pulse),
//   o_rx_overrun (sticky until accept), o_rx_busy (FSM not idle).
// UART_RX_PARITY_EN: when defined, frame is 8E1 and o_rx_parity_err pulses on mismatch.
module uart_rx_8n1 import uart_pkg::*; #(
   parameter int OS_DIV      = DEF_OS_DIV,
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_rx,
   output logic [7:0] o_rx_data,
   output logic       o_rx_valid,
   input  logic       i_rx_ready,
   output logic       o_rx_frame_err,
   output logic       o_rx_overrun,
   output logic       o_rx_busy
`ifdef UART_RX_PARITY_EN
   ,
   output logic       o_rx_parity_err
`endif
);
   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev, r_valid, r_frame_err, r_overrun, r_busy;
   logic [7:0]             r_data, r_shift, w_shift;
   logic [3:0]             r_sc, w_sc;
   logic [2:0]             r_bc, w_bc;
   state_t                 r_state, w_state;
   logic                   w_rx_s, w_tick, w_done, w_ferr, w_perr, w_pbad, w_accept;

   uart_baud_tick #(.OS_DIV(OS_DIV)) u_tick (.clk(clk), .rst(rst), .o_tick(w_tick));

   assign w_rx_s   = r_sync[SYNC_STAGES-1];
   assign w_accept = r_valid & i_rx_ready;

   always_comb begin
      w_state = r_state;
      w_sc    = r_sc;
      w_bc    = r_bc;
      w_shift = r_shift;
      w_done  = 1'b0;
      w_ferr  = 1'b0;
      w_perr  = 1'b0;
      if (w_tick) begin
         w_sc = r_sc + 4'd1;
         case (r_state)
            // prev resets to 0, so a line held low through reset is not a start edge
            S_IDLE:  if (r_prev && !w_rx_s) begin
               w_state = S_START;
               w_sc    = '0;
            end
            S_START: if (r_sc == MID_SAMPLE) begin
               w_state = w_rx_s ? S_IDLE : S_DATA;
               w_sc    = '0;
               w_bc    = '0;
            end
            // sc wraps 15->0 by itself, so each data sample lands one bit after the last
            S_DATA:  if (r_sc == LAST_SAMPLE) begin
               w_shift = {w_rx_s, r_shift[7:1]};
               w_bc    = r_bc + 3'd1;
`ifdef UART_RX_PARITY_EN
               w_state = (r_bc == 3'd7) ? S_PARITY : S_DATA;
`else
               w_state = (r_bc == 3'd7) ? S_STOP : S_DATA;
`endif
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: if (r_sc == LAST_SAMPLE) begin
               w_perr  = w_rx_s ^ (^r_shift);
               w_state = S_STOP;
            end
`endif
            S_STOP:  if (r_sc == LAST_SAMPLE) begin
               w_state = w_rx_s ? S_IDLE : S_BREAK;
               w_done  = w_rx_s & ~w_pbad;
               w_ferr  = ~w_rx_s;
            end
            S_BREAK: if (w_rx_s) w_state = S_IDLE;
            default: w_state = S_IDLE;
         endcase
      end
   end

`ifdef UART_RX_PARITY_EN
   logic r_pbad, r_parity_err;
   assign w_pbad          = r_pbad;
   assign o_rx_parity_err = r_parity_err;
   always_ff @(posedge clk) begin
      r_pbad       <= (rst || r_state == S_START) ? 1'b0 : (r_pbad | w_perr);
      r_parity_err <= rst ? 1'b0 : w_perr;
   end
`else
   assign w_pbad = w_perr;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync      <= '1;
         r_prev      <= 1'b0;
         r_state     <= S_IDLE;
         r_sc        <= '0;
         r_bc        <= '0;
         r_shift     <= '0;
         r_data      <= '0;
         r_valid     <= 1'b0;
         r_frame_err <= 1'b0;
         r_overrun   <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_sync      <= {r_sync[SYNC_STAGES-2:0], i_rx};
         r_prev      <= w_tick ? w_rx_s : r_prev;
         r_state     <= w_state;
         r_sc        <= w_sc;
         r_bc        <= w_bc;
         r_shift     <= w_shift;
         // a finished byte only lands when the holder is empty or being drained this cycle
         r_data      <= (w_done && (!r_valid || w_accept)) ? r_shift : r_data;
         r_valid     <= w_done ? 1'b1 : (w_accept ? 1'b0 : r_valid);
         r_overrun   <= w_accept ? 1'b0 : ((w_done && r_valid) ? 1'b1 : r_overrun);
         r_frame_err <= w_ferr;
         r_busy      <= (w_state != S_IDLE);
      end
   end

   assign o_rx_data      = r_data;
   assign o_rx_valid     = r_valid;
   assign o_rx_frame_err = r_frame_err;
   assign o_rx_overrun   = r_overrun;
   assign o_rx_busy      = r_busy;
endmodule

// File: tb/tb_uart_rx_8n1.sv
// tb_uart_rx_8n1: directed bench for uart_rx_8n1 with an expected-byte scoreboard.
// The DUT runs at OS_DIV=26 (416 clk/bit) so the whole plan fits a short run;
// glitch and baud-tolerance stimuli are scaled to the same fractions of a bit.
module tb_uart_rx_8n1;
   localparam int OS_DIV = 26;
   localparam int BIT    = OS_DIV * 16;

   logic       clk = 1'b0, rst = 1'b1, i_rx = 1'b1, i_rx_ready = 1'b1;
   logic [7:0] o_rx_data;
   logic       o_rx_valid, o_rx_frame_err, o_rx_overrun, o_rx_busy;
   int         vectors = 0, miscompares = 0, n_valid = 0, n_ferr = 0, nv, nf;
   logic       pv = 1'b0;
   logic [7:0] q[$];
   logic [7:0] exp_b;

   always #5 clk = ~clk;

   uart_rx_8n1 #(.OS_DIV(OS_DIV), .SYNC_STAGES(2)) dut (
      .clk(clk), .rst(rst), .i_rx(i_rx), .o_rx_data(o_rx_data), .o_rx_valid(o_rx_valid),
      .i_rx_ready(i_rx_ready), .o_rx_frame_err(o_rx_frame_err), .o_rx_overrun(o_rx_overrun),
      .o_rx_busy(o_rx_busy)
   );

   always @(negedge clk) begin
      if (!rst) begin
         if (o_rx_valid && !pv) n_valid++;
         if (o_rx_frame_err) n_ferr++;
         if (o_rx_valid && i_rx_ready) begin
            vectors++;
            assert (q.size() != 0) else begin
               miscompares++;
               $error("FAIL unexpected_byte: got %02h, scoreboard empty", o_rx_data);
            end
            if (q.size() != 0) begin
               exp_b = q.pop_front();
               vectors++;
               assert (o_rx_data === exp_b) else begin
                  miscompares++;
                  $error("FAIL rx_data: got %02h expected %02h", o_rx_data, exp_b);
               end
            end
         end
      end
      pv = o_rx_valid;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_clks(input int n);
      repeat (n) @(posedge clk);
   endtask

   task automatic send_byte(input logic [7:0] d, input int n, input logic stop);
      i_rx = 1'b0;
      wait_clks(n);
      for (int i = 0; i < 8; i++) begin
         i_rx = d[i];
         wait_clks(n);
      end
      i_rx = stop;
      wait_clks(n);
   endtask

   initial begin
      wait_clks(5);
      @(negedge clk);
      chk("reset_data", o_rx_data, 8'h00);
      chk("reset_valid", o_rx_valid, 1'b0);
      chk("reset_ferr", o_rx_frame_err, 1'b0);
      chk("reset_overrun", o_rx_overrun, 1'b0);
      chk("reset_busy", o_rx_busy, 1'b0);
      @(posedge clk);
      #1 rst = 1'b0;
      wait_clks(BIT);

      q.push_back(8'h44);
      send_byte(8'h44, BIT, 1'b1);
      wait_clks(BIT);
      chk("d_valid_count", n_valid, 1);
      chk("d_ferr_count", n_ferr, 0);
      chk("d_overrun", o_rx_overrun, 1'b0);

      i_rx = 1'b0;
      wait_clks(BIT * 2 / 5);
      i_rx = 1'b1;
      wait_clks(BIT * 3 / 2);
      chk("glitch_valid_count", n_valid, 1);
      chk("glitch_ferr_count", n_ferr, 0);
      chk("glitch_overrun", o_rx_overrun, 1'b0);
      chk("glitch_busy", o_rx_busy, 1'b0);

      send_byte(8'h55, BIT, 1'b0);
      wait_clks(BIT);
      @(negedge clk);
      chk("ferr_count", n_ferr, 1);
      chk("ferr_valid", o_rx_valid, 1'b0);
      chk("ferr_break_busy", o_rx_busy, 1'b1);
      i_rx = 1'b1;
      wait_clks(BIT);
      @(negedge clk);
      chk("ferr_recovered_busy", o_rx_busy, 1'b0);
      chk("ferr_valid_count", n_valid, 1);

      @(posedge clk);
      #1 i_rx_ready = 1'b0;
      q.push_back(8'h12);
      send_byte(8'h12, BIT, 1'b1);
      send_byte(8'hA5, BIT, 1'b1);
      wait_clks(BIT);
      @(negedge clk);
      chk("ovr_valid", o_rx_valid, 1'b1);
      chk("ovr_data_kept", o_rx_data, 8'h12);
      chk("ovr_flag", o_rx_overrun, 1'b1);
      @(posedge clk);
      #1 i_rx_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("ovr_accept_valid", o_rx_valid, 1'b0);
      chk("ovr_accept_overrun", o_rx_overrun, 1'b0);

      nv = n_valid;
      nf = n_ferr;
      i_rx = 1'b0;
      wait_clks(BIT * 3 + BIT / 2);
      @(negedge clk);
      chk("midframe_busy", o_rx_busy, 1'b1);
      rst = 1'b1;
      wait_clks(3);
      @(negedge clk);
      chk("rst_busy", o_rx_busy, 1'b0);
      chk("rst_valid", o_rx_valid, 1'b0);
      @(posedge clk);
      #1 rst = 1'b0;
      wait_clks(BIT);
      @(negedge clk);
      chk("low_after_rst_busy", o_rx_busy, 1'b0);
      i_rx = 1'b1;
      wait_clks(BIT);
      q.push_back(8'h3C);
      send_byte(8'h3C, BIT, 1'b1);
      wait_clks(BIT);
      chk("rst_resume_count", n_valid, nv + 1);
      chk("rst_resume_ferr", n_ferr, nf);

      q.push_back(8'hC3);
      send_byte(8'hC3, BIT - BIT / 50, 1'b1);
      wait_clks(BIT);
      q.push_back(8'hC3);
      send_byte(8'hC3, BIT + BIT / 50, 1'b1);
      wait_clks(BIT);
      chk("tol_valid_count", n_valid, nv + 3);
      chk("final_ferr_count", n_ferr, 1);
      chk("final_overrun", o_rx_overrun, 1'b0);
      chk("scoreboard_drained", q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/uart_rx_8n1.md
Name: uart_rx_8n1

Overview:
- 8N1 UART receiver on the board's `uartrx` pin.
- Oversamples the asynchronous serial line at 16x the baud rate, derived from the 12 MHz internal-oscillator domain.
- Delivers each received byte through a valid/ready holding register, with framing-error and overrun reporting.
- Sits directly upstream of on-chip consumers (LED control, echo to `uart_tx_8n1`); it is the receive-side counterpart of the existing transmitter.

Parameters:
- OS_DIV, 78, system clocks per oversample tick (12 MHz / (9600*16) = 78.125, truncated).
- OS_RATE, 16, oversample ticks per bit; fixed at 16 and not overridable.
- SYNC_STAGES, 2, synchroniser flops on `rx` (minimum 2).

Ports:
- clk  in  1  system clock (12 MHz from SB_HFOSC).
- rst  in  1  synchronous, active-high reset.
- rx  in  1  asynchronous serial input, idle high.
- rx_data  out  8  received byte; valid while rx_valid=1.
- rx_valid  out  1  holding register full.
- rx_ready  in  1  consumer accepts byte when rx_valid & rx_ready.
- rx_frame_err  out  1  one-cycle pulse: stop bit sampled low.
- rx_overrun  out  1  sticky: byte dropped because holding register was full.
- rx_busy  out  1  high whenever FSM is not IDLE.

Behaviour:
- Interface: one clock (`clk`); reset `rst` is synchronous and active-high. All outputs are registered.
- Reset values: rx_data=0x00, rx_valid=0, rx_frame_err=0, rx_overrun=0, rx_busy=0, FSM=IDLE, tick counter=0, synchroniser flops=1, `prev`=0.
- Synchroniser: `rx` passes through SYNC_STAGES flops to give rx_s. All logic below uses rx_s only.
- Tick generator: free-running counter 0..OS_DIV-1. `tick` is asserted for one clk when count==OS_DIV-1, then the counter wraps to 0.
- `prev` register: samples rx_s on every tick; reset to 0.
  - Start detection requires prev=1 and rx_s=0 on a tick.
  - A line held low through reset is therefore never taken as a start bit.
- FSM, advancing on ticks only. Tick count `sc` is 4 bits; bit count `bc` is 3 bits.
  - IDLE: on the start condition, go to START with sc=0.
  - START: when sc==7 (mid-bit), if rx_s=0 go to DATA with sc=0, bc=0; else return to IDLE (glitch rejected, no flags).
  - DATA: when sc==15, shift rx_s into the shift register LSB-first and clear sc. After bc==7, go to STOP.
  - STOP: when sc==15, sample rx_s.
    - rx_s=1: byte complete; go to IDLE.
    - rx_s=0: pulse rx_frame_err, discard the byte, go to BREAK.
  - BREAK: wait until rx_s=1 on a tick, then go to IDLE.
- Latency: rx_valid rises 1 clk after the stop-bit mid-sample tick, about 9.5 bit periods after the start edge.
- Handshake:
  - Accept = rx_valid & rx_ready. On accept, rx_valid clears and rx_overrun clears.
  - rx_data is held stable while rx_valid=1.
- Boundary conditions:
  - Byte completes while rx_valid=1 and no accept that cycle: new byte dropped, old rx_data kept, rx_overrun set.
  - Byte completes in the same cycle as an accept: new byte loaded, rx_valid stays 1, no overrun.
  - Frame error while rx_valid=1: only rx_frame_err pulses; the holding register is untouched.
  - rst asserted mid-frame: return to IDLE next clk and discard the partial byte and held byte. Normal reception resumes only after a falling edge on the line following reset.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Frame is 8E1. A PARITY state is inserted between DATA and STOP, sampled at sc==15.
  - Output port rx_parity_err (1 bit) pulses one clk on even-parity mismatch; the byte is discarded; the FSM continues to STOP.
  - Latency grows by one bit period.
- Undefined: no PARITY state, no rx_parity_err port; pure 8N1.

Decomposition:
- Shared package `uart_pkg`:
  - FSM state encoding: IDLE, START, DATA, PARITY, STOP, BREAK.
  - OS_RATE=16, MID_SAMPLE=7, LAST_SAMPLE=15.
  - Default OS_DIV for 12 MHz/9600.
- Sub-module `uart_baud_tick`: parameterised OS_DIV counter producing `tick`, reusable by a future oversampled transmitter.

Test Plan:
- Send 0x44 ('D') at 1248 clk/bit with rx_ready=1 -> rx_valid pulses once, rx_data=0x44, no error flags.
- 0.4-bit (500 clk) low glitch on an idle line -> FSM returns to IDLE; rx_valid, rx_frame_err and rx_overrun all stay 0.
- Send 0x55 with the stop bit forced low -> rx_frame_err pulses once, rx_valid=0; no new byte until the line returns high.
- rx_ready=0; send 0x12 then 0xA5 -> rx_data=0x12, rx_overrun=1; after accept rx_valid=0 and rx_overrun=0.
- Assert rst during bit 3 of 0xF0 with the line held low, release, then send 0x3C -> 0x3C received correctly, no spurious byte.
- Baud tolerance: send 0xC3 at ±2% bit period (1223 and 1273 clk) -> rx_data=0xC3 in both cases.
